// File: rtl/vga_pkg.sv
// Shared constants and types for the duck hunt stage.
// Holds the enemy opponent tuning values and its FSM state encoding.
package vga_pkg;

  // Fixed part of the enemy reaction time, in milliseconds.
  localparam int ENEMY_MIN_DELAY_MS = 400;

  // Enemy score saturates here so it always fits two display digits.
  localparam int ENEMY_SCORE_MAX = 99;

  // Enemy opponent life cycle; exported on a debug port of enemy_hunter_ctl.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DUCK = 2'd1,
    ST_AIM       = 2'd2,
    ST_COOLDOWN  = 2'd3
  } enemy_state_t;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [6:0] sat_inc7(input logic [6:0] value,
                                          input logic [6:0] max_value);
    return (value >= max_value) ? max_value : value + 7'd1;
  endfunction

endpackage

// File: rtl/enemy_hunter_ctl_ms_tick_gen.sv
// 1 ms prescaler. Emits a one-cycle tick every CLK_FREQ_HZ/1000 clocks.
// 'clear' holds the count at zero, so the first tick after clear is released
// arrives exactly one full millisecond later. Usable by any game timer.
module ms_tick_gen #(
  parameter int CLK_FREQ_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 2;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1)) && !clear;

  // Free-running divider that wraps on the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/enemy_hunter_ctl.sv
// Computer opponent for the duck hunt stage.
// Waits a pseudo-random reaction time after each duck appears; if the player
// has not hit the duck by then, it fires a one-cycle enemy_hit pulse and
// bumps the enemy score. The player always wins a same-cycle tie.
module enemy_hunter_ctl
  import vga_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 65_000_000,
  parameter int LFSR_WIDTH   = 10,
  parameter int MIN_DELAY_MS = ENEMY_MIN_DELAY_MS,
  parameter int SCORE_MAX    = ENEMY_SCORE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_enable,
  input  logic                  hunt_start,
  input  logic                  target_killed,
  input  logic [LFSR_WIDTH-1:0] lfsr_number,
  output logic [6:0]            enemy_score,
  output logic                  enemy_hit,
  output logic                  enemy_aiming,
  output enemy_state_t          dbg_state
);

  // Delay width: at least 11 bits, wider if the parameters demand it.
  localparam int DELAY_W_RAW = $clog2(MIN_DELAY_MS + (1 << LFSR_WIDTH));
  localparam int DELAY_W     = (DELAY_W_RAW > 11) ? DELAY_W_RAW : 11;

  enemy_state_t       state;
  enemy_state_t       state_next;
  logic               hunt_q;
  logic               hunt_rise;
  logic               expire;
  logic               ms_tick;
  logic               presc_clear;
  logic [DELAY_W-1:0] delay_ms;
  logic [DELAY_W-1:0] ms_cnt;

  assign dbg_state   = state;
  assign hunt_rise   = hunt_start && !hunt_q;
  // The prescaler only runs while aiming; every AIM entry starts at a clean ms.
  assign presc_clear = (state != ST_AIM);

  ms_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(presc_clear),
    .tick (ms_tick)
  );

  // Next-state logic; a player kill or vanished duck beats timer expiry.
  always_comb begin
    state_next = state;
    expire     = 1'b0;
    if (!game_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_WAIT_DUCK;
        end
        ST_WAIT_DUCK: begin
          if (hunt_rise) begin
            state_next = ST_AIM;
          end
        end
        ST_AIM: begin
          if (target_killed || !hunt_start) begin
            state_next = ST_COOLDOWN;
          end else if (ms_cnt == delay_ms) begin
            state_next = ST_COOLDOWN;
            expire     = 1'b1;
          end
        end
        ST_COOLDOWN: begin
          // Wait for the duck to be gone so one duck is never scored twice.
          if (!hunt_start && !target_killed) begin
            state_next = ST_WAIT_DUCK;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register, reaction timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      hunt_q       <= 1'b0;
      delay_ms     <= '0;
      ms_cnt       <= '0;
      enemy_score  <= '0;
      enemy_hit    <= 1'b0;
      enemy_aiming <= 1'b0;
    end else begin
      state        <= state_next;
      hunt_q       <= hunt_start;
      enemy_hit    <= expire;
      enemy_aiming <= (state_next == ST_AIM);

      // Each new game starts from zero; the score is held while idle.
      if (state == ST_IDLE && game_enable) begin
        enemy_score <= '0;
      end else if (expire) begin
        enemy_score <= sat_inc7(enemy_score, 7'(SCORE_MAX));
      end

      if (state == ST_WAIT_DUCK && state_next == ST_AIM) begin
        delay_ms <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_number);
        ms_cnt   <= '0;
      end else if (state == ST_AIM && ms_tick) begin
        ms_cnt <= ms_cnt + DELAY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enemy_hunter_ctl.sv
// Self-checking bench for enemy_hunter_ctl at 10 clocks per ms, 4 ms minimum delay.
module tb_enemy_hunter_ctl;
  import vga_pkg::*;

  localparam int CPM    = 10;
  localparam int MIN_MS = 4;
  localparam int SMAX   = 99;

  logic         clk = 1'b0;
  logic         rst;
  logic         game_enable;
  logic         hunt_start;
  logic         target_killed;
  logic [9:0]   lfsr_number;
  logic [6:0]   enemy_score;
  logic         enemy_hit;
  logic         enemy_aiming;
  enemy_state_t dbg_state;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] model_score = 7'd0;
  logic [6:0] sb_exp;
  logic       hit_prev = 1'b0;

  always #5 clk = ~clk;

  enemy_hunter_ctl #(
    .CLK_FREQ_HZ (10_000),
    .LFSR_WIDTH  (10),
    .MIN_DELAY_MS(MIN_MS),
    .SCORE_MAX   (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_enable  (game_enable),
    .hunt_start   (hunt_start),
    .target_killed(target_killed),
    .lfsr_number  (lfsr_number),
    .enemy_score  (enemy_score),
    .enemy_hit    (enemy_hit),
    .enemy_aiming (enemy_aiming),
    .dbg_state    (dbg_state)
  );

  assert property (@(posedge clk) disable iff (rst) enemy_hit |=> !enemy_hit)
    else $error("FAIL double_hit: enemy_hit high on two consecutive cycles");

  // Scoreboard: every enemy_hit pulse must match an expected score in order.
  always @(negedge clk) begin
    if (enemy_hit) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_hit: enemy_hit=1 score=%0d, no hit expected", enemy_score);
      end else begin
        sb_exp = exp_q.pop_front();
        if (enemy_score !== sb_exp)
          $display("FAIL hit_score: got %0d, want %0d", enemy_score, sb_exp);
        else
          n_pass++;
      end
      if (hit_prev) begin
        n_checks++;
        $display("FAIL hit_width: enemy_hit high %0d cycles in a row, want 1", 2);
      end
    end
    hit_prev = enemy_hit;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_hunt(input logic [9:0] lfsr);
    lfsr_number = lfsr;
    hunt_start  = 1'b1;
  endtask

  task automatic end_hunt();
    hunt_start    = 1'b0;
    target_killed = 1'b0;
    tick(3);
  endtask

  // Drives one duck the enemy should shoot; returns latency in negedges.
  task automatic do_hit(input logic [9:0] lfsr, input logic release_after,
                        output int lat, output logic aim_ok);
    int want;
    want = (MIN_MS + int'(lfsr)) * CPM + 2;
    model_score = (model_score >= 7'(SMAX)) ? 7'(SMAX) : model_score + 7'd1;
    exp_q.push_back(model_score);
    start_hunt(lfsr);
    lat    = 0;
    aim_ok = 1'b1;
    for (int k = 1; k <= want + 50; k++) begin
      @(negedge clk);
      if (enemy_hit) begin
        lat = k;
        break;
      end
      if (!enemy_aiming) aim_ok = 1'b0;
    end
    n_checks++;
    if (lat != want) begin
      $display("FAIL hit_latency: got %0d cycles, want %0d (lfsr=%0d)", lat, want, lfsr);
      if (lat == 0) void'(exp_q.pop_back());
    end else n_pass++;
    if (release_after) end_hunt();
  endtask

  task automatic test_reset();
    rst = 1'b1; game_enable = 1'b0; hunt_start = 1'b0;
    target_killed = 1'b0; lfsr_number = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (enemy_score !== 7'd0) $display("FAIL reset_score: got %0d, want 0", enemy_score); else n_pass++;
    n_checks++;
    if (enemy_hit !== 1'b0) $display("FAIL reset_hit: got %0b, want 0", enemy_hit); else n_pass++;
    n_checks++;
    if (enemy_aiming !== 1'b0) $display("FAIL reset_aiming: got %0b, want 0", enemy_aiming); else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d, want %0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_enable();
    game_enable = 1'b1;
    model_score = 7'd0;
    tick(1);
    n_checks++;
    if (dbg_state !== ST_WAIT_DUCK) $display("FAIL enable_state: got %0d, want %0d", dbg_state, ST_WAIT_DUCK); else n_pass++;
  endtask

  task automatic test_basic_hit();
    int lat;
    logic aim_ok;
    do_hit(10'd6, 1'b0, lat, aim_ok);
    n_checks++;
    if (aim_ok !== 1'b1) $display("FAIL basic_aiming: got %0b, want 1 throughout", aim_ok); else n_pass++;
    n_checks++;
    if (enemy_score !== 7'd1) $display("FAIL basic_score: got %0d, want 1", enemy_score); else n_pass++;
    end_hunt();
  endtask

  task automatic test_player_kill();
    start_hunt(10'd6);
    tick(51);
    n_checks++;
    if (enemy_aiming !== 1'b1) $display("FAIL kill_aiming_before: got %0b, want 1", enemy_aiming); else n_pass++;
    target_killed = 1'b1;
    tick(1);
    n_checks++;
    if (enemy_aiming !== 1'b0) $display("FAIL kill_aiming_after: got %0b, want 0", enemy_aiming); else n_pass++;
    n_checks++;
    if (dbg_state !== ST_COOLDOWN) $display("FAIL kill_state: got %0d, want %0d", dbg_state, ST_COOLDOWN); else n_pass++;
    tick(150);
    n_checks++;
    if (enemy_score !== model_score) $display("FAIL kill_score: got %0d, want %0d", enemy_score, model_score); else n_pass++;
    end_hunt();
  endtask

  task automatic test_expiry_tie();
    start_hunt(10'd6);
    tick(101);
    target_killed = 1'b1;
    tick(1);
    n_checks++;
    if (enemy_hit !== 1'b0) $display("FAIL tie_hit: got %0b, want 0", enemy_hit); else n_pass++;
    n_checks++;
    if (dbg_state !== ST_COOLDOWN) $display("FAIL tie_state: got %0d, want %0d", dbg_state, ST_COOLDOWN); else n_pass++;
    tick(20);
    n_checks++;
    if (enemy_score !== model_score) $display("FAIL tie_score: got %0d, want %0d", enemy_score, model_score); else n_pass++;
    end_hunt();
  endtask

  task automatic test_random_hunts();
    int lat;
    logic aim_ok;
    for (int i = 0; i < 4; i++) begin
      do_hit(10'($urandom_range(0, 20)), 1'b1, lat, aim_ok);
      n_checks++;
      if (aim_ok !== 1'b1) $display("FAIL random_aiming: got %0b, want 1 (hunt %0d)", aim_ok, i); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic aim_ok;
    while (model_score < 7'(SMAX)) do_hit(10'd0, 1'b1, lat, aim_ok);
    n_checks++;
    if (enemy_score !== 7'(SMAX)) $display("FAIL preload_score: got %0d, want %0d", enemy_score, SMAX); else n_pass++;
    do_hit(10'd0, 1'b1, lat, aim_ok);
    n_checks++;
    if (enemy_score !== 7'(SMAX)) $display("FAIL sat_score: got %0d, want %0d", enemy_score, SMAX); else n_pass++;
  endtask

  task automatic test_disable_mid_aim();
    start_hunt(10'd3);
    tick(20);
    game_enable = 1'b0;
    tick(1);
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL disable_state: got %0d, want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++;
    if (enemy_aiming !== 1'b0) $display("FAIL disable_aiming: got %0b, want 0", enemy_aiming); else n_pass++;
    tick(100);
    n_checks++;
    if (enemy_score !== model_score) $display("FAIL disable_hold: got %0d, want %0d", enemy_score, model_score); else n_pass++;
    hunt_start  = 1'b0;
    game_enable = 1'b1;
    model_score = 7'd0;
    tick(1);
    n_checks++;
    if (enemy_score !== 7'd0) $display("FAIL reenable_score: got %0d, want 0", enemy_score); else n_pass++;
    tick(2);
  endtask

  task automatic test_hold_after_hit();
    int lat;
    int pulses;
    logic aim_ok;
    logic stuck_ok;
    do_hit(10'd2, 1'b0, lat, aim_ok);
    pulses   = 0;
    stuck_ok = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (enemy_hit) pulses++;
      if (dbg_state != ST_COOLDOWN || enemy_aiming) stuck_ok = 1'b0;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL hold_pulses: got %0d extra pulses, want 0", pulses); else n_pass++;
    n_checks++;
    if (stuck_ok !== 1'b1) $display("FAIL hold_cooldown: got %0b, want 1 (stay in COOLDOWN)", stuck_ok); else n_pass++;
    end_hunt();
  endtask

  task automatic test_reset_mid_aim();
    start_hunt(10'd5);
    tick(30);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (enemy_aiming !== 1'b0) $display("FAIL rst_aiming: got %0b, want 0", enemy_aiming); else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d, want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++;
    if (enemy_score !== 7'd0) $display("FAIL rst_score: got %0d, want 0", enemy_score); else n_pass++;
    rst         = 1'b0;
    hunt_start  = 1'b0;
    model_score = 7'd0;
    tick(150);
    n_checks++;
    if (dbg_state !== ST_WAIT_DUCK) $display("FAIL rst_resume: got %0d, want %0d", dbg_state, ST_WAIT_DUCK); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_basic_hit();
    test_player_kill();
    test_expiry_tie();
    test_random_hunts();
    test_saturation();
    test_disable_mid_aim();
    test_hold_after_hit();
    test_reset_mid_aim();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_hits: got %0d unmatched, want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
